// File: rtl/uart_pkg.sv
// Shared constants for the scheduled UART transmitter: FSM encoding,
// baud select codes and the post-frame gap length.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Idle cycles after the stop bit so the baud generator counter can clear.
  localparam int GAP_LEN = 2;

  // Codes above the fastest rate fall back to the slowest, safest rate.
  function automatic logic [2:0] baud_fix(input logic [2:0] code);
    return (code > BAUD_115200) ? BAUD_9600 : code;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after the last
// granted requester and wraps, so a requester that keeps req high only wins
// again after every other active requester has had a turn.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int          idx;
  logic        found;
  logic [IW-1:0] sel;

  // First active requester at or after last+1, modulo NREQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Multi-requester UART transmitter: arbitrates one byte at a time from NREQ
// requesters and serialises it as start / DW data (LSB first) / stop, pacing
// each bit on clk_bps from an external baud generator, then idles a short gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [2:0]         cfg_baud,
  output logic [NREQ-1:0]    gnt,
  output logic               bps_start,
  input  logic               clk_bps,
  output logic [2:0]         baud_sel,
  output logic               tx,
  output logic               busy
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int GW = $clog2(GAP_LEN + 1);

  logic [2:0]      state;
  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic [DW-1:0]   sel_data;
  logic [DW-1:0]   shreg;
  logic [BW-1:0]   bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            take;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req     (req),
    .last    (last_grant),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grants only happen from IDLE; reset masks the combinational pulse.
  assign take = (state == ST_IDLE) && (|req) && !rst;
  assign gnt  = take ? arb_gnt : '0;

  // Byte of the winning requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_gnt[i]) sel_data = sel_data | req_data[i*DW +: DW];
  end

  // Frame FSM and shifter; tx is registered so every line change lands one
  // cycle after the grant or bit tick that caused it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      bps_start  <= 1'b0;
      busy       <= 1'b0;
      baud_sel   <= BAUD_9600;
      last_grant <= IW'(NREQ - 1);
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (take) begin
          state      <= ST_START;
          tx         <= 1'b0;
          bps_start  <= 1'b1;
          busy       <= 1'b1;
          baud_sel   <= baud_fix(cfg_baud);
          last_grant <= arb_idx;
          shreg      <= sel_data;
          bit_cnt    <= '0;
        end
        ST_START: if (clk_bps) begin
          state   <= ST_DATA;
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        ST_DATA: if (clk_bps) begin
          if (bit_cnt == BW'(DW - 1)) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end else begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: if (clk_bps) begin
          state     <= ST_GAP;
          bps_start <= 1'b0;
          gap_cnt   <= '0;
        end
        ST_GAP: begin
          if (gap_cnt == GW'(GAP_LEN - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic, all
// checked by a frame-level reference model running on the falling edge.
module tb_uart_tx_sched;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int GAP_LEN = 2;

  logic               clk, rst, clk_bps;
  logic [NREQ-1:0]    req, gnt;
  logic [NREQ*DW-1:0] req_data;
  logic [2:0]         cfg_baud, baud_sel;
  logic               bps_start, tx, busy;

  uart_tx_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .cfg_baud  (cfg_baud),
    .gnt       (gnt),
    .bps_start (bps_start),
    .clk_bps   (clk_bps),
    .baud_sel  (baud_sel),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Baud generator stub: 0 = tick every div cycles while bps_start,
  // 1 = random ticks regardless of state, 2 = silent.
  int bps_mode = 0;
  int div      = 434;
  int bcnt     = 0;
  initial clk_bps = 1'b0;
  always begin
    @(posedge clk);
    #1;
    case (bps_mode)
      0: begin
        if (bps_start) begin
          bcnt++;
          if (bcnt >= div) begin clk_bps = 1'b1; bcnt = 0; end
          else clk_bps = 1'b0;
        end else begin
          bcnt = 0; clk_bps = 1'b0;
        end
      end
      1: clk_bps = ($urandom_range(0, 3) == 0);
      default: clk_bps = 1'b0;
    endcase
  end

  // Round-robin winner by plain modular search; -1 when nobody asks.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    int i;
    for (int k = 1; k <= NREQ; k++) begin
      i = (last + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: frame-level expectations of the line and handshakes.
  int            m_last = NREQ - 1;
  int            ph     = 0;        // 0 idle, 1 frame, 2 gap
  int            ticks  = 0;
  int            gcnt   = 0;
  int            m_w;
  logic [DW+1:0] m_bits;
  logic [DW-1:0] m_d;
  logic [2:0]    m_baud = 3'd0;
  bit            pend   = 0;
  logic          exp_tx, exp_bps, exp_busy;
  int            gq[$];

  // Falling-edge monitor: settle pending expectations, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_tx", tx, 1);
      chk("rst_bps", bps_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_baud", baud_sel, 0);
      m_last = NREQ - 1; ph = 0; pend = 0;
    end else begin
      if (pend) begin
        chk("tx", tx, exp_tx);
        chk("bps_start", bps_start, exp_bps);
        chk("busy", busy, exp_busy);
        chk("baud_sel", baud_sel, m_baud);
        pend = 0;
      end
      case (ph)
        0: begin
          chk("idle_tx", tx, 1);
          chk("idle_bps", bps_start, 0);
          chk("idle_busy", busy, 0);
          m_w = rr_pick(req, m_last);
          if (m_w < 0) chk("gnt_idle", gnt, 0);
          else begin
            chk("gnt", gnt, 32'(1) << m_w);
            m_last = m_w;
            m_d    = DW'(req_data >> (m_w * DW));
            m_bits = {1'b1, m_d, 1'b0};
            m_baud = (cfg_baud > 3'd4) ? 3'd0 : cfg_baud;
            gq.push_back(m_w);
            ph = 1; ticks = 0;
            pend = 1; exp_tx = 1'b0; exp_bps = 1'b1; exp_busy = 1'b1;
          end
        end
        1: begin
          chk("gnt_busy", gnt, 0);
          if (clk_bps) begin
            ticks++;
            pend = 1; exp_busy = 1'b1;
            if (ticks <= DW + 1) begin exp_tx = m_bits[ticks]; exp_bps = 1'b1; end
            else begin exp_tx = 1'b1; exp_bps = 1'b0; ph = 2; gcnt = 0; end
          end
        end
        default: begin
          chk("gnt_gap", gnt, 0);
          chk("gap_busy", busy, 1);
          chk("gap_bps", bps_start, 0);
          gcnt++;
          if (gcnt == GAP_LEN) begin
            ph = 0; pend = 1; exp_tx = 1'b1; exp_bps = 1'b0; exp_busy = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input int n0, input int budget);
    int n = 0;
    while (gq.size() <= n0 && n < budget) begin step(); n++; end
    if (gq.size() <= n0) chk("timeout_gnt", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(ph == 0 && busy == 1'b0) && n < budget) begin step(); n++; end
    if (!(ph == 0 && busy == 1'b0)) chk("timeout_idle", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_bps", bps_start, 0);
    chk("async_rst_busy", busy, 0);
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0, n, prev_n;
    rst = 1'b1; req = '0; req_data = '0; cfg_baud = 3'd0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single request, 434-cycle ticks, 0xA5 from requester 1.
    bps_mode = 0; div = 434;
    req_data = {$urandom};
    req_data[15:8] = 8'hA5;
    cfg_baud = 3'd4;
    n0 = gq.size();
    req = 4'b0010;
    wait_gnt(n0, 20);
    req = '0;
    if (gq.size() > n0) chk("single_who", gq[n0], 1);
    chk("single_baud", baud_sel, 4);
    wait_idle(6000);

    // Contention from reset: 0,1,2,3,0.
    div = 5;
    do_reset();
    n0 = gq.size();
    req = 4'b1111;
    n = 0;
    while (gq.size() < n0 + 5 && n < 1000) begin step(); n++; end
    req = '0;
    if (gq.size() < n0 + 5) chk("timeout_contention", 0, 1);
    else for (int k = 0; k < 5; k++) chk("rr_order", gq[n0 + k], k % 4);
    wait_idle(200);

    // Starvation: req0 held, req2 arrives mid-frame -> 2 goes next.
    do_reset();
    n0 = gq.size();
    req = 4'b0001;
    wait_gnt(n0, 20);
    repeat (10) step();
    req = 4'b0101;
    wait_gnt(n0 + 1, 500);
    req = '0;
    if (gq.size() > n0 + 1) chk("starve_next", gq[n0 + 1], 2);
    wait_idle(200);

    // Reset mid-DATA after three ticks, then a fresh grant to 0.
    n0 = gq.size();
    req = 4'b0001;
    wait_gnt(n0, 20);
    n = 0;
    while (!(ph == 1 && ticks >= 3) && n < 200) begin step(); n++; end
    chk("mid_data_reached", (ph == 1 && ticks >= 3), 1);
    do_reset();
    n0 = gq.size();
    wait_gnt(n0, 5);
    req = '0;
    if (gq.size() > n0) chk("post_rst_who", gq[n0], 0);
    wait_idle(200);

    // Bad baud code latches as 0 and ignores later cfg changes.
    n0 = gq.size();
    cfg_baud = 3'd7;
    req = 4'b1000;
    wait_gnt(n0, 20);
    cfg_baud = 3'd2;
    req = '0;
    repeat (20) step();
    chk("bad_cfg_mid", baud_sel, 0);
    wait_idle(200);

    // Spurious ticks while idle with no requests.
    n0 = gq.size();
    bps_mode = 1;
    repeat (60) step();
    chk("spur_no_gnt", gq.size(), n0);
    chk("spur_tx", tx, 1);

    // Randomized traffic: random ticks, random data/config, occasional reset.
    prev_n = gq.size();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin bps_mode = 0; div = 3; end
      while (prev_n < gq.size()) begin
        if ($urandom_range(0, 1) == 0) req[gq[prev_n]] = 1'b0;
        prev_n++;
      end
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b1;
      req_data = {$urandom};
      cfg_baud = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1499) == 0) do_reset();
      else step();
    end
    req = '0;
    bps_mode = 0;
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DW, default 8, data bits per frame.
REQ-003 clk  in  1  system clock; single clock domain (50 MHz).
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 req  in  NREQ  per-requester transmit request, level, held until granted.
REQ-006 req_data  in  NREQ*DW  packed bytes; requester i occupies bits [i*DW +: DW].
REQ-007 cfg_baud  in  3  baud select code 0..4 (9600..115200); sampled only at grant.
REQ-008 gnt  out  NREQ  one-hot, one-cycle pulse marking the byte taken from requester i.
REQ-009 bps_start  out  1  enable to the baud generator; high for the whole frame.
REQ-010 clk_bps  in  1  one-cycle bit-tick pulse from the baud generator.
REQ-011 baud_sel  out  3  baud code driven to the baud generator; held constant for the frame.
REQ-012 tx  out  1  serial line, idle high.
REQ-013 busy  out  1  high from the cycle after grant until return to IDLE.

Function
REQ-014 States SHALL be IDLE, START, DATA, STOP, GAP.
REQ-015 In IDLE with any req bit high, the block SHALL grant exactly one requester in that cycle.
- gnt[i] pulses.
- req_data slice i latched.
- cfg_baud latched into baud_sel.
- Next state START.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-017 In START, tx=0 and bps_start=1; each clk_bps pulse SHALL advance START->DATA->...->STOP.
REQ-018 DATA SHALL shift DW bits out LSB first, one bit per clk_bps pulse, with a bit counter of width clog2(DW).
REQ-019 In STOP, tx=1; on clk_bps the block SHALL move to GAP and drop bps_start.
REQ-020 GAP SHALL last exactly 2 clk cycles, so the generator counter clears; then IDLE.
REQ-021 tx SHALL be registered; a change follows the triggering clk_bps or grant edge by 1 cycle.
REQ-022 Ignore rules:
- req changes during a frame are ignored; a new grant occurs only in IDLE.
- clk_bps is ignored in IDLE and GAP.
- A clk_bps in the grant cycle is ignored.
REQ-023 cfg_baud values 5..7 SHALL latch as 0 (9600).
REQ-024 Grant-to-IDLE latency SHALL be 1 + (DW+2) bit ticks + 2 cycles, and gnt SHALL never pulse while busy=1.
REQ-025 A requester holding req after its grant SHALL be regranted only after every other active requester has been served once.

Reset
REQ-026 While rst is high, all of the following SHALL hold immediately, asynchronously, including mid-frame:
- state=IDLE, tx=1, bps_start=0, busy=0, gnt=0.
- baud_sel=0, last_grant=NREQ-1, shift register and bit counter=0.
REQ-027 A frame cut by reset SHALL NOT resume; the first grant after reset follows REQ-016.

Structure
REQ-028 State encoding, baud code constants (BAUD_9600=0 .. BAUD_115200=4) and GAP length SHALL live in shared package uart_pkg.
REQ-029 The round-robin picker SHALL be sub-module rr_arbiter, a combinational one-hot grant from req and last_grant with parameter NREQ; the FSM and shifter stay in uart_tx_sched.

Verification
REQ-030 Directed scenarios:
- Single request: req=4'b0010, data1=8'hA5, cfg_baud=4, clk_bps stub ticks every 434 cycles -> gnt=4'b0010 one cycle; tx sequence 0,1,0,1,0,0,1,0,1,1; baud_sel=4; busy drops 2 cycles after bps_start falls.
- Contention: req=4'b1111 held, four frames -> grant order 0,1,2,3, then 0 again.
- Starvation check: req0 held, req2 pulsed once mid-frame-of-0 and held -> next grant is 2, not 0.
- Reset mid-DATA (after 3 ticks): rst=1 -> same-cycle tx=1, bps_start=0, busy=0; release with req=4'b0001 -> gnt=4'b0001.
- Bad config: cfg_baud=7 at grant, then changed to 2 mid-frame -> baud_sel=0 for the whole frame.
- Spurious tick: clk_bps pulsing in IDLE with req=0 -> tx stays 1, bps_start stays 0, no gnt.
